// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared FSM encoding, trigger modes and word-layout helpers for the ADC capture controller
package adc_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int pad_w(input int prec, input int chb);
    return 16 - prec - chb;
  endfunction
endpackage

// File: rtl/adc_capture_ctrl_toggle_sync.sv
// toggle_sync: 2-FF synchroniser for a cross-domain toggle, emitting a one-cycle pulse per edge
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[1:0], tgl};
  assign pulse = s[2] ^ s[1];
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered, decimating multi-channel ADC capture serialised into tagged 16-bit FIFO words
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int PRECISION = 10,
  parameter int NUM_CH    = 4,
  parameter int CH_BITS   = 2,
  parameter int DECIM_W   = 8,
  parameter int LEN_W     = 16
) (
  input  logic                        adc_clk,
  input  logic                        rst,
  input  logic [NUM_CH*PRECISION-1:0] adc_code_in,
  input  logic                        adc_valid,
  input  logic                        start_tgl,
  input  logic                        abort_tgl,
  input  logic [1:0]                  trig_mode,
  input  logic [PRECISION-1:0]        trig_level,
  input  logic [DECIM_W-1:0]          decim,
  input  logic [LEN_W-1:0]            capture_len,
  input  logic                        fifo_full,
  output logic [15:0]                 fifo_din,
  output logic                        fifo_wr_en,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [LEN_W-1:0]            frame_count
);
  if (pad_w(PRECISION, CH_BITS) < 0 || CH_BITS != tag_w(NUM_CH)) begin : g_bad_cfg
    $error("adc_capture_ctrl: PRECISION+CH_BITS must fit 16 bits and CH_BITS must match NUM_CH");
  end
  state_t state, state_nx;
  logic start_p, abort_p, arm, primed, edge_mode, trig_hit, len_hit, accept;
  logic ser_act, ser_last, ser_busy;
  logic [CH_BITS-1:0] ser_idx;
  logic [DECIM_W-1:0] dcnt;
  logic [PRECISION-1:0] ch0, prev_ch0;
  logic [NUM_CH*PRECISION-1:0] frame_q;
  toggle_sync u_start (.clk(adc_clk), .rst(rst), .tgl(start_tgl), .pulse(start_p));
  toggle_sync u_abort (.clk(adc_clk), .rst(rst), .tgl(abort_tgl), .pulse(abort_p));
  assign ch0       = adc_code_in[PRECISION-1:0];
  assign edge_mode = trig_mode == TRIG_RISE || trig_mode == TRIG_FALL;
  assign trig_hit  = adc_valid && primed &&
                     (trig_mode == TRIG_RISE ? prev_ch0 < trig_level && ch0 >= trig_level :
                      trig_mode == TRIG_FALL ? prev_ch0 > trig_level && ch0 <= trig_level : 1'b0);
  assign len_hit   = capture_len != '0 && frame_count == capture_len;
  assign ser_last  = ser_idx == CH_BITS'(NUM_CH - 1);
  // the word on the bus during the last slot frees the serialiser for a same-cycle frame
  assign ser_busy  = ser_act && !ser_last;
  assign arm       = start_p && !abort_p && (state == IDLE || state == DONE);
  assign accept    = !abort_p && (state == ARMED ? edge_mode && trig_hit :
                     state == CAPTURE && adc_valid && dcnt == '0 && !len_hit);
  always_ff @(posedge adc_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = abort_p ? IDLE :
               (state == IDLE || state == DONE) ? (start_p ? ARMED : state) :
               state == ARMED ? (!edge_mode || trig_hit ? CAPTURE : ARMED) :
               (len_hit && !ser_busy ? DONE : CAPTURE);
  always_comb begin
    busy       = state == ARMED || state == CAPTURE;
    done       = state == DONE;
    fifo_wr_en = ser_act && !fifo_full;
    fifo_din   = 16'(frame_q[ser_idx*PRECISION +: PRECISION]) | (16'(ser_idx) << (16 - CH_BITS));
  end
  always_ff @(posedge adc_clk or posedge rst)
    if (rst) begin
      prev_ch0    <= '0;
      primed      <= 1'b0;
      dcnt        <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      ser_act     <= 1'b0;
      ser_idx     <= '0;
      frame_q     <= '0;
    end else begin
      if (adc_valid) prev_ch0 <= ch0;
      if (arm) begin
        primed      <= 1'b0;
        dcnt        <= '0;
        frame_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (state == ARMED && adc_valid) primed <= 1'b1;
        if (accept) dcnt <= decim;
        else if (state == CAPTURE && adc_valid && dcnt != '0) dcnt <= dcnt - 1'b1;
        if (accept && !ser_busy) frame_count <= frame_count + 1'b1;
        if ((accept && ser_busy) || (ser_act && fifo_full)) overflow <= 1'b1;
      end
      if (abort_p) begin
        ser_act <= 1'b0;
        ser_idx <= '0;
      end else if (accept && !ser_busy) begin
        ser_act <= 1'b1;
        ser_idx <= '0;
        frame_q <= adc_code_in;
      end else if (ser_act) begin
        ser_act <= !ser_last;
        ser_idx <= ser_last ? '0 : ser_idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: table, directed and randomized checks against a frame-level capture model
module tb_adc_capture_ctrl;
  localparam int P = 10, N = 4, CB = 2, DW = 8, LW = 16;
  typedef struct {int dec; int len; int nv; int gap; int words; int fc;} vec_t;
  logic clk = 0, rst = 1;
  logic [N*P-1:0] adc_code_in = '0;
  logic adc_valid = 0, start_tgl = 0, abort_tgl = 0, fifo_full = 0;
  logic [1:0] trig_mode = 0;
  logic [P-1:0] trig_level = 0;
  logic [DW-1:0] decim = 0;
  logic [LW-1:0] capture_len = 0, frame_count;
  logic [15:0] fifo_din;
  logic fifo_wr_en, busy, done, overflow;
  logic [15:0] got[$];
  int vectors = 0, miscompares = 0;
  vec_t tbl[5];
  adc_capture_ctrl dut (
    .adc_clk(clk), .rst(rst), .adc_code_in(adc_code_in), .adc_valid(adc_valid),
    .start_tgl(start_tgl), .abort_tgl(abort_tgl), .trig_mode(trig_mode),
    .trig_level(trig_level), .decim(decim), .capture_len(capture_len),
    .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .busy(busy), .done(done), .overflow(overflow), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (fifo_wr_en) got.push_back(fifo_din);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  function automatic logic [15:0] word(input int k, input logic [N*P-1:0] f);
    return (16'(k) << (16 - CB)) | 16'(f[k*P +: P]);
  endfunction
  function automatic logic [N*P-1:0] rnd_frame();
    return (N*P)'({$urandom(), $urandom()});
  endfunction
  task automatic send(input logic [N*P-1:0] f, input int gap);
    adc_code_in = f;
    adc_valid = 1;
    tick;
    adc_valid = 0;
    repeat (gap - 1) tick;
  endtask
  task automatic rearm;
    abort_tgl = ~abort_tgl;
    repeat (6) tick;
    start_tgl = ~start_tgl;
    repeat (6) tick;
    got.delete();
  endtask
  // model: keep every (decim+1)-th frame from the first, stop after capture_len frames
  task automatic run_capture(input int dec, input int len, input int nv, input int gap);
    logic [15:0] exp_q[$];
    logic [N*P-1:0] fr;
    int cap = 0;
    decim = DW'(dec);
    capture_len = LW'(len);
    trig_mode = 0;
    rearm();
    for (int i = 0; i < nv; i++) begin
      fr = rnd_frame();
      if (i % (dec + 1) == 0 && (len == 0 || cap < len)) begin
        cap++;
        for (int k = 0; k < N; k++) exp_q.push_back(word(k, fr));
      end
      send(fr, gap);
    end
    repeat (N + 3) tick;
    chk("word_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("word", got[i], exp_q[i]);
    chk("frame_count", frame_count, cap);
    chk("done", done, (len != 0 && cap == len) ? 1 : 0);
  endtask
  initial begin
    logic [N*P-1:0] fr[6];
    tbl[0] = '{0, 3, 3, 8, 12, 3};
    tbl[1] = '{2, 2, 9, 8, 8, 2};
    tbl[2] = '{1, 3, 4, 6, 8, 2};
    tbl[3] = '{0, 0, 5, 5, 20, 5};
    tbl[4] = '{3, 1, 2, 4, 4, 1};
    repeat (3) tick;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_count", frame_count, 0);
    rst = 0;
    tick;
    for (int t = 0; t < 5; t++) begin
      run_capture(tbl[t].dec, tbl[t].len, tbl[t].nv, tbl[t].gap);
      chk("tbl_words", got.size(), tbl[t].words);
      chk("tbl_fc", frame_count, tbl[t].fc);
    end
    for (int r = 0; r < 6; r++)
      run_capture($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 12), $urandom_range(4, 9));
    trig_mode = 1; trig_level = 512; decim = 0; capture_len = 1;
    rearm();
    send({30'($urandom()), 10'd600}, 8);
    send({30'($urandom()), 10'd500}, 8);
    send({30'($urandom()), 10'd510}, 8);
    chk("rise_armed_busy", busy, 1);
    chk("rise_armed_words", got.size(), 0);
    send({30'($urandom()), 10'd520}, 8);
    send({30'($urandom()), 10'd530}, 8);
    chk("rise_words", got.size(), 4);
    if (got.size() > 0) chk("rise_code", got[0], 520);
    chk("rise_done", done, 1);
    chk("rise_fc", frame_count, 1);
    trig_mode = 2;
    rearm();
    send({30'($urandom()), 10'd600}, 8);
    send({30'($urandom()), 10'd520}, 8);
    send({30'($urandom()), 10'd512}, 8);
    chk("fall_words", got.size(), 4);
    if (got.size() > 0) chk("fall_code", got[0], 512);
    trig_mode = 0; capture_len = 1;
    rearm();
    fr[0] = rnd_frame();
    adc_code_in = fr[0]; adc_valid = 1;
    tick;
    adc_valid = 0;
    tick;
    tick;
    fifo_full = 1;
    tick;
    fifo_full = 0;
    repeat (6) tick;
    chk("full_words", got.size(), 3);
    if (got.size() == 3) chk("full_last_word", got[2], word(3, fr[0]));
    chk("full_overflow", overflow, 1);
    chk("full_done", done, 1);
    capture_len = 0;
    rearm();
    for (int i = 0; i < 6; i++) begin
      fr[i] = rnd_frame();
      send(fr[i], 2);
    end
    repeat (6) tick;
    chk("fast_words", got.size(), 12);
    if (got.size() >= 12) begin
      chk("fast_w4", got[4], word(0, fr[2]));
      chk("fast_w8", got[8], word(0, fr[4]));
    end
    chk("fast_overflow", overflow, 1);
    chk("fast_fc", frame_count, 3);
    rearm();
    chk("rearm_overflow", overflow, 0);
    chk("rearm_fc", frame_count, 0);
    send(rnd_frame(), 2);
    abort_tgl = ~abort_tgl;
    repeat (4) tick;
    got.delete();
    for (int i = 0; i < 3; i++) send(rnd_frame(), 4);
    chk("abort_words", got.size(), 0);
    chk("abort_busy", busy, 0);
    start_tgl = ~start_tgl;
    repeat (6) tick;
    chk("restart_busy", busy, 1);
    start_tgl = ~start_tgl;
    abort_tgl = ~abort_tgl;
    repeat (6) tick;
    chk("both_busy", busy, 0);
    chk("both_done", done, 0);
    rearm();
    send(rnd_frame(), 1);
    chk("pre_rst_wr_en", fifo_wr_en, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_wr_en", fifo_wr_en, 0);
    chk("async_rst_busy", busy, 0);
    tick;
    rst = 0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
